// File: rtl/instr_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
interface instr_queue_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [127:0]     fetch_instr_pc;
    logic             write_fifo;
    logic             jump;
    logic             stop_fetch;
    logic             rd_valid;
    logic             rd_ready;
    logic [127:0]     rd_bundle;
    logic [CNT_W-1:0] count;
    logic             overflow_err;

    // Front-end side: fetch, branch unit and decode
    modport master (
        output fetch_instr_pc, write_fifo, jump, rd_ready,
        input  stop_fetch, rd_valid, rd_bundle, count, overflow_err
    );

    // Queue side
    modport slave (
        input  fetch_instr_pc, write_fifo, jump, rd_ready,
        output stop_fetch, rd_valid, rd_bundle, count, overflow_err
    );
endinterface

// File: rtl/instr_queue.sv
// Dual-issue instruction bundle queue between fetch and decode.
// DEPTH must be a power of two >= 4; AFULL_SLACK in 1..DEPTH-1.
// Bundle layout: [31:0] pc0, [63:32] instr0, [95:64] pc1, [127:96] instr1.
module instr_queue #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned AFULL_SLACK = 2
) (
    input  logic            clk,
    input  logic            rst,
    instr_queue_if.slave    q
);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned STOP_LVL = DEPTH - AFULL_SLACK;

    logic [127:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             stop_q;
    logic             ovf_q;

    logic             full_c;
    logic             pop_c;
    logic             push_c;
    logic             drop_c;
    logic             store_c;
    logic [CNT_W-1:0] count_next_c;
    logic             stop_next_c;

    // Handshake decode and next occupancy; a pop frees the slot a full-queue push reuses
    always_comb begin
        full_c       = (count_q == CNT_W'(DEPTH));
        pop_c        = (count_q != '0) && q.rd_ready;
        push_c       = q.write_fifo && (!full_c || pop_c);
        drop_c       = q.write_fifo && full_c && !pop_c;
        store_c      = push_c && !q.jump && !rst;
        count_next_c = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        stop_next_c  = (count_next_c >= CNT_W'(STOP_LVL));
    end

    // Pointers, occupancy and back-pressure; flush beats push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            stop_q  <= 1'b0;
        end else if (q.jump) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            stop_q  <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_next_c;
            stop_q  <= stop_next_c;
        end
    end

    // Sticky drop flag; a flush-time push is discarded silently
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop_c && !q.jump) begin
            ovf_q <= 1'b1;
        end
    end

    // Bundle storage; contents are don't-care after reset so no reset here
    always_ff @(posedge clk) begin
        if (store_c) begin
            mem[wr_ptr] <= q.fetch_instr_pc;
        end
    end

    assign q.rd_valid     = (count_q != '0);
    assign q.rd_bundle    = mem[rd_ptr];
    assign q.count        = count_q;
    assign q.stop_fetch   = stop_q;
    assign q.overflow_err = ovf_q;

endmodule

// File: doc/instr_queue.md
# instr_queue

Decoupling buffer between the dual-issue fetch stage and decode. Fetch pushes 128-bit bundles of two instructions with their PCs into the buffer. Decode pops whole bundles in order over a valid/ready handshake. The block sends back-pressure to fetch on `stop_fetch`, early enough to absorb fetch's in-flight bundles, and discards all contents when a jump redirects the front end.

## Interface

- `DEPTH`, 8: number of bundle entries. Must be a power of two, ≥ 4.
- `AFULL_SLACK`, 2: free entries still remaining when `stop_fetch` asserts. Range 1..DEPTH-1.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous reset, active-high
- `fetch_instr_pc`  in  128  bundle from fetch. Layout: [31:0] pc0, [63:32] instr0, [95:64] pc1, [127:96] instr1. Slot 0 is older.
- `write_fifo`  in  1  push strobe; `fetch_instr_pc` is valid this cycle
- `jump`  in  1  redirect/flush request from the branch unit
- `stop_fetch`  out  1  registered back-pressure to fetch
- `rd_valid`  out  1  head entry is present
- `rd_ready`  in  1  decode accepts the head entry
- `rd_bundle`  out  128  head entry, same layout as `fetch_instr_pc`
- `count`  out  $clog2(DEPTH)+1  current occupancy, registered
- `overflow_err`  out  1  sticky flag: a push was dropped while the queue was full

## Operation

- Storage: circular array of DEPTH×128. Pointers `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits wide and wrap modulo DEPTH. `count` is tracked explicitly.
- Pop: occurs when `rd_valid && rd_ready`. `rd_ptr` increments.
- Push: accepted when `write_fifo && (count < DEPTH || pop)`. The bundle is written at `wr_ptr` and `wr_ptr` increments. When the queue is full and a pop occurs in the same cycle, the push is accepted and `count` stays at DEPTH.
- Drop: `write_fifo` with the queue full and no pop. The bundle is discarded, pointers hold, and `overflow_err` is set to 1. Only `rst` clears `overflow_err`. A flush does not clear it.
- Count update: count_next = count + push − pop.
- Flush: `jump` = 1 has priority over push and pop in the same cycle. On the next edge:
  - `wr_ptr`, `rd_ptr` and `count` are set to 0.
  - `stop_fetch` is set to 0.
  - A concurrent push is dropped without setting `overflow_err`.
  - A concurrent pop handshake still completes from decode's point of view; decode must itself discard that bundle under `jump`.
- `rd_valid` = (`count` != 0). `rd_bundle` = mem[`rd_ptr`], driven combinationally from registered storage.
- No bypass: a bundle pushed into an empty queue is not visible in the same cycle.
- Back-pressure: `stop_fetch` <= (count_next ≥ DEPTH − AFULL_SLACK), evaluated every non-flush cycle.
- Reset (`rst` = 1 at an edge), including reset in the middle of operation:
  - Pointers, `count`, `stop_fetch` and `overflow_err` are set to 0.
  - Storage contents are don't-care.
  - Pushes and pops during reset are ignored.

## Timing

- Reset values: `stop_fetch` = 0, `rd_valid` = 0, `count` = 0, `overflow_err` = 0. `rd_bundle` is undefined while `rd_valid` = 0.
- Push-to-visible latency is 1 cycle: push at edge N gives `rd_valid` = 1 and the bundle on `rd_bundle` after edge N.
- `stop_fetch` changes at the same edge as the `count` update that causes it, so it is 1 cycle after the triggering push/pop strobe.
- Fetch may issue up to AFULL_SLACK further pushes after `stop_fetch` rises without any drop.
- Decode may hold `rd_ready` = 1 continuously, giving one pop per cycle. `rd_bundle` is held stable while `rd_valid` && !`rd_ready`.
- After `jump`: `rd_valid` = 0 on the following cycle. A new push in the cycle after `jump` is accepted normally.

## Test plan

- Reset: assert `rst` for 2 cycles with `write_fifo` = 1 -> `count` = 0, `rd_valid` = 0, `stop_fetch` = 0, `overflow_err` = 0.
- Back-pressure (DEPTH = 8, AFULL_SLACK = 2, `rd_ready` = 0): push 5 bundles -> `stop_fetch` = 0. Push a 6th -> `stop_fetch` = 1 after that edge and `count` = 6. Pop one -> `stop_fetch` = 0.
- Overflow: with `rd_ready` = 0, push 9 bundles with distinct PCs 0x1000 + 8·i -> `count` = 8 and `overflow_err` = 1. Draining yields exactly the first 8 bundles, in order.
- Full plus simultaneous traffic: with `count` = 8, assert `write_fifo` and `rd_ready` together -> `count` stays 8, `overflow_err` stays 0, and the new bundle appears after the 7 remaining older ones.
- Flush: with `count` = 5, assert `jump` together with `write_fifo` -> next cycle `count` = 0, `rd_valid` = 0, `stop_fetch` = 0, `overflow_err` = 0. The next push is read back correctly.
- Wrap-around: stream 40 bundles with random `write_fifo`/`rd_ready` duty and `rd_ready` held low for 3-cycle bursts -> scoreboard shows in-order delivery, no loss unless `overflow_err` is set, and `count` always equals pushes − pops.
